// File: rtl/note_pkg.sv
// Shared types and constants for the note sequencer.
// Decode groups are seven codes wide, one pitch per code.
package note_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_KEY,
    S_SOUND,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;

  typedef enum logic [1:0] {
    DUR_4,
    DUR_8,
    DUR_16
  } dur_t;

  localparam logic [5:0] BASE_M8  = 6'd1;
  localparam logic [5:0] BASE_M4  = 6'd8;
  localparam logic [5:0] BASE_M16 = 6'd15;
  localparam logic [5:0] BASE_L8  = 6'd22;
  localparam logic [5:0] BASE_L4  = 6'd29;
  localparam logic [5:0] BASE_L16 = 6'd36;
  localparam logic [5:0] BASE_H8  = 6'd43;
  localparam logic [5:0] BASE_H4  = 6'd50;
  localparam logic [5:0] BASE_H16 = 6'd57;

  // 7-bit compare so the top group (57..63) does not wrap
  function automatic logic in_grp(
    input logic [5:0] c,
    input logic [5:0] b
  );
    return ({1'b0, c} >= {1'b0, b}) &&
           ({1'b0, c} < ({1'b0, b} + 7'd7));
  endfunction

  function automatic logic [2:0] grp_pitch(
    input logic [5:0] c,
    input logic [5:0] b
  );
    logic [5:0] d;
    d = c - b + 6'd1;
    return d[2:0];
  endfunction

endpackage

// File: rtl/note_decode.sv
// Note code to pitch/octave/duration decoder.
// Pure combinational; also used by the free-play LED path.
module note_decode
  import note_pkg::*;
(
  input  logic [5:0] code,
  output logic [2:0] pitch,
  output logic [1:0] octave,
  output dur_t       dur
);

  always_comb begin
    pitch  = 3'd0;
    octave = OCT_LOW;
    dur    = DUR_8;
    unique case (1'b1)
      (code == 6'd0): begin
        pitch  = 3'd0;
      end
      in_grp(code, BASE_M8): begin
        pitch  = grp_pitch(code, BASE_M8);
        octave = OCT_MID;
        dur    = DUR_8;
      end
      in_grp(code, BASE_M4): begin
        pitch  = grp_pitch(code, BASE_M4);
        octave = OCT_MID;
        dur    = DUR_4;
      end
      in_grp(code, BASE_M16): begin
        pitch  = grp_pitch(code, BASE_M16);
        octave = OCT_MID;
        dur    = DUR_16;
      end
      in_grp(code, BASE_L8): begin
        pitch  = grp_pitch(code, BASE_L8);
        octave = OCT_LOW;
        dur    = DUR_8;
      end
      in_grp(code, BASE_L4): begin
        pitch  = grp_pitch(code, BASE_L4);
        octave = OCT_LOW;
        dur    = DUR_4;
      end
      in_grp(code, BASE_L16): begin
        pitch  = grp_pitch(code, BASE_L16);
        octave = OCT_LOW;
        dur    = DUR_16;
      end
      in_grp(code, BASE_H8): begin
        pitch  = grp_pitch(code, BASE_H8);
        octave = OCT_HIGH;
        dur    = DUR_8;
      end
      in_grp(code, BASE_H4): begin
        pitch  = grp_pitch(code, BASE_H4);
        octave = OCT_HIGH;
        dur    = DUR_4;
      end
      in_grp(code, BASE_H16): begin
        pitch  = grp_pitch(code, BASE_H16);
        octave = OCT_HIGH;
        dur    = DUR_16;
      end
      default: begin
        pitch  = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/note_sequencer.sv
// Song playback controller: walks the note ROM, times each note,
// and in learn mode waits for the matching key before sounding.
module note_sequencer
  import note_pkg::*;
#(
  parameter int IDX_W     = 8,
  parameter int TICK_DIV  = 500000,
  parameter int DUR_Q     = 40,
  parameter int GAP_TICKS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               learn,
  input  logic [1:0]         song_sel,
  input  logic [IDX_W-1:0]   song_len,
  output logic [IDX_W+1:0]   rom_addr,
  input  logic [5:0]         rom_data,
  input  logic               key_valid,
  input  logic [2:0]         key_pitch,
  input  logic [1:0]         key_oct,
  output logic               busy,
  output logic               sound_en,
  output logic [2:0]         pitch,
  output logic [1:0]         octave,
  output logic [IDX_W-1:0]   index,
  output logic               wait_key,
  output logic               done,
  output logic [7:0]         hits,
  output logic [7:0]         misses
);

  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam int TCK_W = $clog2(DUR_Q + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [TCK_W-1:0] L_Q4  = TCK_W'(DUR_Q - GAP_TICKS - 1);
  localparam logic [TCK_W-1:0] L_Q8  = TCK_W'(DUR_Q / 2 - GAP_TICKS - 1);
  localparam logic [TCK_W-1:0] L_Q16 = TCK_W'(DUR_Q / 4 - GAP_TICKS - 1);
  localparam logic [TCK_W-1:0] L_GAP = TCK_W'(GAP_TICKS - 1);

  state_t             state;
  logic [1:0]         song_q;
  logic [IDX_W-1:0]   len_q;
  logic               learn_q;
  dur_t               dur_q;
  logic [PRE_W-1:0]   pre;
  logic [TCK_W-1:0]   tcnt;
  logic [TCK_W-1:0]   last;
  logic               tick;
  logic               phase_end;
  logic               key_hit;
  logic [IDX_W-1:0]   idx_nx;
  logic [2:0]         d_pitch;
  logic [1:0]         d_oct;
  dur_t               d_dur;

  note_decode u_dec (
    .code   (rom_data),
    .pitch  (d_pitch),
    .octave (d_oct),
    .dur    (d_dur)
  );

  always_comb begin
    last = L_GAP;
    if (state == S_SOUND) begin
      case (dur_q)
        DUR_4:   last = L_Q4;
        DUR_16:  last = L_Q16;
        default: last = L_Q8;
      endcase
    end
  end

  assign tick      = (pre == PRE_LAST);
  assign phase_end = tick && (tcnt == last);
  assign key_hit   = (key_pitch == pitch) && (key_oct == octave);
  assign idx_nx    = index + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      song_q   <= 2'd0;
      len_q    <= '0;
      learn_q  <= 1'b0;
      dur_q    <= DUR_8;
      pre      <= '0;
      tcnt     <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      sound_en <= 1'b0;
      pitch    <= 3'd0;
      octave   <= OCT_LOW;
      index    <= '0;
      wait_key <= 1'b0;
      done     <= 1'b0;
      hits     <= 8'd0;
      misses   <= 8'd0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        sound_en <= 1'b0;
        wait_key <= 1'b0;
        pitch    <= 3'd0;
        octave   <= OCT_LOW;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              song_q  <= song_sel;
              len_q   <= song_len;
              learn_q <= learn;
              index   <= '0;
              hits    <= 8'd0;
              misses  <= 8'd0;
              busy    <= 1'b1;
              if (song_len == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state    <= S_FETCH;
                rom_addr <= {song_sel, {IDX_W{1'b0}}};
              end
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            pitch  <= d_pitch;
            octave <= d_oct;
            dur_q  <= d_dur;
            if (learn_q && d_pitch != 3'd0) begin
              state    <= S_WAIT_KEY;
              wait_key <= 1'b1;
            end else begin
              state    <= S_SOUND;
              sound_en <= (d_pitch != 3'd0) && !pause;
              pre      <= '0;
              tcnt     <= '0;
            end
          end
          S_WAIT_KEY: begin
            if (key_valid) begin
              if (key_hit) begin
                hits     <= (hits == 8'hFF) ? hits : hits + 8'd1;
                state    <= S_SOUND;
                wait_key <= 1'b0;
                sound_en <= !pause;
                pre      <= '0;
                tcnt     <= '0;
              end else begin
                misses <= (misses == 8'hFF) ? misses : misses + 8'd1;
              end
            end
          end
          S_SOUND: begin
            if (pause) begin
              sound_en <= 1'b0;
            end else if (phase_end) begin
              state    <= S_GAP;
              sound_en <= 1'b0;
              pre      <= '0;
              tcnt     <= '0;
            end else begin
              sound_en <= (pitch != 3'd0);
              if (tick) begin
                pre  <= '0;
                tcnt <= tcnt + TCK_W'(1);
              end else begin
                pre <= pre + PRE_W'(1);
              end
            end
          end
          S_GAP: begin
            if (!pause) begin
              if (phase_end) begin
                index <= idx_nx;
                if (idx_nx == len_q) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  state    <= S_FETCH;
                  rom_addr <= {song_q, idx_nx};
                end
              end else if (tick) begin
                pre  <= '0;
                tcnt <= tcnt + TCK_W'(1);
              end else begin
                pre <= pre + PRE_W'(1);
              end
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            pitch  <= 3'd0;
            octave <= OCT_LOW;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a small timeline model.
// Fast timing: TICK_DIV=2, DUR_Q=8, GAP_TICKS=1.
module tb_note_sequencer;
  import note_pkg::*;

  localparam int TD = 2;
  localparam int DQ = 8;
  localparam int GT = 1;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          learn = 1'b0;
  logic [1:0]    song_sel = 2'd0;
  logic [IW-1:0] song_len = '0;
  logic [IW+1:0] rom_addr;
  logic [5:0]    rom_data = 6'd0;
  logic          key_valid = 1'b0;
  logic [2:0]    key_pitch = 3'd0;
  logic [1:0]    key_oct = 2'd0;
  logic          busy, sound_en, wait_key, done;
  logic [2:0]    pitch;
  logic [1:0]    octave;
  logic [IW-1:0] index;
  logic [7:0]    hits, misses;

  logic [5:0]    dcode = 6'd0;
  logic [2:0]    dp;
  logic [1:0]    dox;
  dur_t          dd;

  logic [5:0]    rom [0:1023];

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          b;
    logic          s;
    logic [2:0]    p;
    logic [1:0]    o;
    logic [IW-1:0] i;
    logic          d;
  } obs_t;

  obs_t exp_q[$];

  note_sequencer #(
    .IDX_W(IW), .TICK_DIV(TD), .DUR_Q(DQ), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .pause(pause), .learn(learn), .song_sel(song_sel),
    .song_len(song_len), .rom_addr(rom_addr), .rom_data(rom_data),
    .key_valid(key_valid), .key_pitch(key_pitch), .key_oct(key_oct),
    .busy(busy), .sound_en(sound_en), .pitch(pitch), .octave(octave),
    .index(index), .wait_key(wait_key), .done(done),
    .hits(hits), .misses(misses)
  );

  note_decode u_dec (.code(dcode), .pitch(dp), .octave(dox), .dur(dd));

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Reference decode from the table: groups of 7, octave mid/low/high,
  // length eighth/quarter/sixteenth cycling within each octave.
  function automatic int m_pitch(int c);
    return (c == 0) ? 0 : ((c - 1) % 7) + 1;
  endfunction

  function automatic int m_oct(int c);
    int g;
    if (c == 0) return 0;
    g = (c - 1) / 7;
    case (g / 3)
      0: return 1;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int m_ticks(int c);
    int g;
    if (c == 0) return DQ / 2;
    g = (c - 1) / 7;
    case (g % 3)
      0: return DQ / 2;
      1: return DQ;
      default: return DQ / 4;
    endcase
  endfunction

  function automatic dur_t m_dur(int c);
    if (m_ticks(c) == DQ) return DUR_4;
    if (m_ticks(c) == DQ / 4) return DUR_16;
    return DUR_8;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic tmo(input string name, input int n, input int bound);
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL %s timeout after %0d cycles", name, n);
    end
  endtask

  function automatic obs_t mk(int b, int s, int p, int o, int i, int d);
    obs_t r;
    r.b = b[0]; r.s = s[0]; r.p = p[2:0];
    r.o = o[1:0]; r.i = i[IW-1:0]; r.d = d[0];
    return r;
  endfunction

  // Expected per-cycle trace of an auto-play song, from FETCH to IDLE
  task automatic push_song(input int song, input int len);
    int pp, po, c, p, o;
    pp = 0; po = 0;
    for (int i = 0; i < len; i++) begin
      c = int'(rom[song * 256 + i]);
      p = m_pitch(c);
      o = m_oct(c);
      exp_q.push_back(mk(1, 0, pp, po, i, 0));
      exp_q.push_back(mk(1, 0, pp, po, i, 0));
      for (int k = 0; k < (m_ticks(c) - GT) * TD; k++)
        exp_q.push_back(mk(1, (p != 0) ? 1 : 0, p, o, i, 0));
      for (int k = 0; k < GT * TD; k++)
        exp_q.push_back(mk(1, 0, p, o, i, 0));
      pp = p; po = o;
    end
    exp_q.push_back(mk(1, 0, pp, po, len, 1));
    exp_q.push_back(mk(0, 0, 0, 0, len, 0));
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {busy, sound_en, pitch, octave, index, done};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL trace t=%0t got b%0b s%0b p%0d o%0d i%0d d%0b want b%0b s%0b p%0d o%0d i%0d d%0b",
          $time, a.b, a.s, a.p, a.o, a.i, a.d,
          e.b, e.s, e.p, e.o, e.i, e.d);
      end
    end
  end

  task automatic go(input int sel, input int len, input bit ln, input bit model);
    @(negedge clk);
    #1;
    if (model) push_song(sel, len);
    song_sel = sel[1:0];
    song_len = len[IW-1:0];
    learn = ln;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tmo(name, n, 400);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int n, hi, lo, tot, wk, dn;
    logic [IW+1:0] ra;

    for (int a = 0; a < 1024; a++) rom[a] = 6'd0;
    rom[0] = 6'd1;   rom[1] = 6'd10;
    rom[256] = 6'd3;
    rom[512] = 6'd0;
    rom[768] = 6'd24; rom[769] = 6'd47; rom[770] = 6'd63;
    rom[771] = 6'd31; rom[772] = 6'd0;

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sound", sound_en, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_index", index, 0);
    chk("rst_hits", hits, 0);

    // model pins: pitch*100 + octave*10 + ticks
    chk("pin21", m_pitch(21) * 100 + m_oct(21) * 10 + m_ticks(21), 712);
    chk("pin22", m_pitch(22) * 100 + m_oct(22) * 10 + m_ticks(22), 104);
    chk("pin42", m_pitch(42) * 100 + m_oct(42) * 10 + m_ticks(42), 702);
    chk("pin43", m_pitch(43) * 100 + m_oct(43) * 10 + m_ticks(43), 124);
    chk("pin56", m_pitch(56) * 100 + m_oct(56) * 10 + m_ticks(56), 728);
    chk("pin57", m_pitch(57) * 100 + m_oct(57) * 10 + m_ticks(57), 122);
    chk("pin_snd1", (m_ticks(1) - GT) * TD, 6);
    chk("pin_snd10", (m_ticks(10) - GT) * TD, 14);

    for (int c = 0; c < 64; c++) begin
      dcode = c[5:0];
      #1;
      checks++;
      if (int'(dp) != m_pitch(c) || int'(dox) != m_oct(c) || dd != m_dur(c)) begin
        failures++;
        $display("FAIL decode code=%0d got p%0d o%0d d%0d want p%0d o%0d d%0d",
          c, dp, dox, dd, m_pitch(c), m_oct(c), m_dur(c));
      end
    end

    @(negedge clk) reset = 1'b1;

    go(0, 2, 1'b0, 1'b1);
    drain("song0");
    go(3, 5, 1'b0, 1'b1);
    drain("song3");

    // learn mode: wrong key, then right key
    go(1, 1, 1'b1, 1'b0);
    n = 0;
    while (!wait_key && n < 20) begin @(negedge clk); n++; end
    tmo("learn_wait", n, 20);
    chk("learn_pitch", pitch, 3);
    chk("learn_oct", octave, 1);
    chk("learn_snd", sound_en, 0);
    key_pitch = 3'd2; key_oct = 2'd1; key_valid = 1'b1;
    @(negedge clk) key_valid = 1'b0;
    chk("miss_cnt", misses, 1);
    chk("miss_hits", hits, 0);
    chk("miss_wait", wait_key, 1);
    key_pitch = 3'd3; key_oct = 2'd1; key_valid = 1'b1;
    @(negedge clk) key_valid = 1'b0;
    chk("hit_cnt", hits, 1);
    chk("hit_wait", wait_key, 0);
    chk("hit_snd", sound_en, 1);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    tmo("learn_done", n, 40);
    @(negedge clk);

    // learn mode rest skips key wait
    go(2, 1, 1'b1, 1'b0);
    n = 0; wk = 0; dn = 0;
    while (!dn && n < 30) begin
      @(negedge clk);
      n++;
      if (wait_key) wk = 1;
      if (done) dn = 1;
    end
    chk("rest_nowait", wk, 0);
    chk("rest_done", dn, 1);
    @(negedge clk);

    // pause for five cycles inside an eighth note
    go(0, 1, 1'b0, 1'b0);
    n = 0;
    while (!sound_en && n < 20) begin @(negedge clk); n++; end
    tmo("pause_rise", n, 20);
    hi = 1; lo = 0; tot = 1;
    fork
      begin
        @(posedge clk); #1;
        @(posedge clk); #1 pause = 1'b1;
        repeat (5) @(posedge clk);
        #1 pause = 1'b0;
      end
      begin
        n = 0;
        while (n < 60) begin
          @(negedge clk);
          n++;
          if (done) break;
          tot++;
          if (sound_en) hi++; else lo++;
        end
        tmo("pause_done", n, 60);
      end
    join
    chk("pause_hi", hi, (m_ticks(1) - GT) * TD);
    chk("pause_lo", lo, 5 + GT * TD);
    chk("pause_len", tot, (m_ticks(1) - GT) * TD + 5 + GT * TD);
    @(negedge clk);

    // start while busy, then stop+start together during note 3
    go(3, 5, 1'b0, 1'b0);
    n = 0;
    while (index != 2 && n < 200) begin @(negedge clk); n++; end
    tmo("busy_idx2", n, 200);
    song_sel = 2'd1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_start_idx", index, 2);
    chk("busy_start_busy", busy, 1);
    n = 0;
    while (!(index == 3 && sound_en) && n < 200) begin @(negedge clk); n++; end
    tmo("stop_wait", n, 200);
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_snd", sound_en, 0);
    chk("stop_idx", index, 3);
    chk("stop_pitch", pitch, 0);
    @(negedge clk);
    chk("stop_idle", busy, 0);

    // zero-length song
    ra = rom_addr;
    song_sel = 2'd2; song_len = '0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    chk("len0_addr", rom_addr, ra);
    @(negedge clk);
    chk("len0_idle", busy, 0);
    chk("len0_done2", done, 0);
    chk("len0_addr2", rom_addr, ra);

    // asynchronous reset mid-song
    go(3, 5, 1'b0, 1'b0);
    n = 0;
    while (!(index == 1 && sound_en) && n < 200) begin @(negedge clk); n++; end
    tmo("arst_wait", n, 200);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_snd", sound_en, 0);
    chk("arst_pitch", pitch, 0);
    chk("arst_idx", index, 0);
    chk("arst_addr", rom_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Playback controller for the buzzer/LED datapath.
- Walks a song held in an external note ROM, one 6-bit note code per entry, and decodes each code into pitch, octave and duration.
- Times the sounding and silent gap of each note with a tick prescaler.
- In learn mode it holds every non-rest note until the player presses the matching key, and counts hits and misses.
- Replaces ad-hoc index/timing logic. Its outputs drive the frequency selector, the note LEDs and the seven-segment display.

Parameters:
- IDX_W, 8: width of the note index and of song_len.
- TICK_DIV, 500000: clk cycles per timing tick.
- DUR_Q, 40: ticks per quarter note. Eighth is DUR_Q/2, sixteenth is DUR_Q/4.
- GAP_TICKS, 2: silent ticks at the end of every note. Must satisfy DUR_Q/4 > GAP_TICKS.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse; begins the selected song from index 0.
- stop, in, 1: one-cycle pulse; abort to IDLE.
- pause, in, 1: level; freezes timing.
- learn, in, 1: level; 0 = auto play, 1 = learn mode. Sampled on start.
- song_sel, in, 2: song number. Sampled on start.
- song_len, in, IDX_W: number of notes in the selected song. Sampled on start.
- rom_addr, out, 2+IDX_W: {song, index} address to the note ROM.
- rom_data, in, 6: note code; valid one cycle after rom_addr.
- key_valid, in, 1: one-cycle pulse; player pressed a key.
- key_pitch, in, 3: pitch of the pressed key, 1..7.
- key_oct, in, 2: octave of the pressed key (0 low, 1 mid, 2 high).
- busy, out, 1: high in any state other than IDLE.
- sound_en, out, 1: buzzer enable.
- pitch, out, 3: pitch of the current note; 0 = rest.
- octave, out, 2: octave of the current note.
- index, out, IDX_W: current note index.
- wait_key, out, 1: high while in WAIT_KEY.
- done, out, 1: one-cycle pulse at song end.
- hits, out, 8: learn-mode correct key count.
- misses, out, 8: learn-mode wrong key count.

Behaviour:
- Reset values: state IDLE; all outputs 0, rom_addr 0, counters 0.

States:
- IDLE: on start, latch song_sel, song_len and learn; set index=0; clear hits and misses. Go to DONE if song_len==0, else to FETCH.
- FETCH (1 cycle): rom_addr = {song, index}.
- LOAD (1 cycle): register rom_data and decode it. Go to WAIT_KEY if learn=1 and the code is not rest, else to SOUND.
- WAIT_KEY: sound_en=0 and wait_key=1. On key_valid:
  - If {key_pitch, key_oct} matches the note: hits++ and go to SOUND.
  - Otherwise: misses++ and stay.
  - No timeout. pause has no effect in this state.
- SOUND: sound_en=1 unless the note is a rest or pause=1. Lasts (dur-GAP_TICKS) ticks, then go to GAP.
- GAP: sound_en=0 for GAP_TICKS ticks. Then index++. Go to DONE if index==song_len, else to FETCH.
- DONE (1 cycle): done=1, then IDLE. index holds its last value.

Timing:
- The prescaler and tick counter clear on entry to SOUND and on entry to GAP.
- They advance only when pause=0 and the state is SOUND or GAP.
- While pause=1, sound_en is forced to 0 and the counts hold.

Decode (code c, 6-bit):
- c=0: rest, eighth.
- 1..7: mid octave, eighth, pitch c.
- 8..14: mid octave, quarter.
- 15..21: mid octave, sixteenth.
- 22..28: low octave, eighth.
- 29..35: low octave, quarter.
- 36..42: low octave, sixteenth.
- 43..49: high octave, eighth.
- 50..56: high octave, quarter.
- 57..63: high octave, sixteenth.
- Pitch within a group = c - group_base + 1.

Precedence and boundary rules:
- stop has priority over start and over every state: next state is IDLE, sound_en=0, counters kept for readout.
- A start while busy is ignored; only stop restarts a song.
- Changes on song_sel, song_len or learn mid-song are ignored.
- hits and misses saturate at 255.
- index never exceeds song_len. song_len=255 is legal.
- Outputs are registered. pitch and octave update in LOAD and hold until the next LOAD.
- pitch, octave and sound_en are cleared on entering IDLE.

Decomposition:
- Package note_pkg holds:
  - state enum;
  - octave constants OCT_LOW/MID/HIGH;
  - duration enum DUR_4/8/16;
  - decode group base constants.
- Sub-module note_decode: combinational 6-bit code to {pitch, octave, dur_class}, shared with the free-play LED logic.

Test Plan:
Bench parameters: TICK_DIV=2, DUR_Q=8, GAP_TICKS=1.
- Auto play, song_len=2, ROM = {1, 10}:
  - Note 0 (mid do, eighth): sound_en high 6 cycles with pitch=1, octave=1, then low 2 cycles.
  - Note 1 (mi, quarter): sound_en high 14 cycles.
  - done pulses once; busy falls the next cycle.
- Learn mode, ROM = {3}:
  - Key (2,1) gives misses=1 and the state stays WAIT_KEY.
  - Key (3,1) gives hits=1, then SOUND starts.
  - Code 0: WAIT_KEY is skipped.
- pause asserted 5 cycles mid-SOUND: sound_en low for those cycles, and the note end is delayed by exactly 5 cycles.
- stop during SOUND of note 3: next cycle busy=0, sound_en=0, index=3. A start in the same cycle as stop is ignored.
- song_len=0 with start: DONE follows within 1 cycle and rom_addr never changes. Reset mid-song: all outputs return to 0 immediately, without a clock edge.
- Exhaustive note_decode sweep of codes 0..63 against the decode table above, including codes 21, 22, 42, 43, 56 and 57.
